// File: rtl/add_pkg.sv
// Shared definitions for the digit-serial integer adder.
//   state_e    : controller states (IDLE / RUN / DONE)
//   nchunk     : number of CHUNK-bit digits in a WIDTH-bit operand
//   cnt_width  : width of a counter/index that must reach n-1 (minimum 1 bit)
//   params_ok  : parameter legality used for elaboration-time checks
package add_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic int nchunk(input int width, input int chunk);
        return (chunk > 0) ? (width / chunk) : 0;
    endfunction

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic bit params_ok(input int width, input int chunk);
        return (chunk >= 1) && (chunk <= width) && ((width % chunk) == 0);
    endfunction

endpackage

// File: rtl/adder_chunk_cin.sv
// CHUNK-bit adder with carry-in/carry-out built from full_adder cells.
//   IMPL_TYPE 0 : plain ripple-carry chain
//   otherwise   : carry-select (ripple low half, two precomputed upper halves)
// Ports:
//   a, b : CHUNK-bit addends
//   cin  : carry-in
//   sum  : CHUNK-bit sum
//   cout : carry-out
module adder_chunk_cin #(
    parameter int CHUNK     = 8,
    parameter int IMPL_TYPE = 0
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout
);

    if (IMPL_TYPE == 0 || CHUNK < 2) begin : g_ripple
        logic [CHUNK:0] c;
        assign c[0] = cin;
        for (genvar i = 0; i < CHUNK; i++) begin : g_fa
            full_adder u_fa (
                .a   (a[i]),
                .b   (b[i]),
                .cin (c[i]),
                .sum (sum[i]),
                .cout(c[i+1])
            );
        end
        assign cout = c[CHUNK];
    end else begin : g_csel
        localparam int LO = CHUNK / 2;
        localparam int HI = CHUNK - LO;

        logic [LO:0]   cl;
        logic [HI:0]   c0;
        logic [HI:0]   c1;
        logic [HI-1:0] s0;
        logic [HI-1:0] s1;

        assign cl[0] = cin;
        assign c0[0] = 1'b0;
        assign c1[0] = 1'b1;

        for (genvar i = 0; i < LO; i++) begin : g_lo
            full_adder u_fa (
                .a   (a[i]),
                .b   (b[i]),
                .cin (cl[i]),
                .sum (sum[i]),
                .cout(cl[i+1])
            );
        end

        // Upper half is evaluated for both possible incoming carries while
        // the lower half ripples; the real low carry then picks one.
        for (genvar i = 0; i < HI; i++) begin : g_hi
            full_adder u_fa0 (
                .a   (a[LO+i]),
                .b   (b[LO+i]),
                .cin (c0[i]),
                .sum (s0[i]),
                .cout(c0[i+1])
            );
            full_adder u_fa1 (
                .a   (a[LO+i]),
                .b   (b[LO+i]),
                .cin (c1[i]),
                .sum (s1[i]),
                .cout(c1[i+1])
            );
        end

        assign sum[CHUNK-1:LO] = cl[LO] ? s1 : s0;
        assign cout            = cl[LO] ? c1[HI] : c0[HI];
    end

endmodule

// File: rtl/full_adder.sv
// 1-bit full adder cell.
//   a, b, cin : addend bits and carry-in
//   sum, cout : sum bit and carry-out
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/add_int_serial.sv
// Digit-serial integer adder/subtractor. One CHUNK-bit digit is added per
// cycle through a single narrow adder; the WIDTH-bit result, carry-out and
// signed overflow are returned behind a valid/ready handshake.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : operand handshake (A, B, sub sampled on acceptance)
//   A, B                : WIDTH-bit operands
//   sub                 : 0 -> A+B, 1 -> A-B
//   out_valid/out_ready : result handshake
//   Sum                 : result modulo 2^WIDTH
//   Cout                : final carry-out (for subtraction, 1 = no borrow)
//   Ovf                 : two's-complement overflow
module add_int_serial
    import add_pkg::*;
#(
    parameter int WIDTH     = 64,
    parameter int CHUNK     = 8,
    parameter int IMPL_TYPE = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Ovf
);

    localparam int NCHUNK = nchunk(WIDTH, CHUNK);
    localparam int CNT_W  = cnt_width(NCHUNK);
    localparam int IDX_W  = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NCHUNK - 1);

    if (!params_ok(WIDTH, CHUNK)) begin : g_param_check
        $error("add_int_serial: WIDTH must be a positive multiple of CHUNK");
    end

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [WIDTH-1:0]   a_q,     a_d;
    logic [WIDTH-1:0]   b_q,     b_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   sum_q,   sum_d;
    logic               cout_q,  cout_d;
    logic               ovf_q,   ovf_d;

    logic [IDX_W-1:0]   base;
    logic [CHUNK-1:0]   chunk_a;
    logic [CHUNK-1:0]   chunk_b;
    logic [CHUNK-1:0]   chunk_sum;
    logic               chunk_cout;
    logic               accept;

    // Digit select: the operands stay put and the counter walks the index,
    // so no wide shifters are needed.
    assign base    = IDX_W'(IDX_W'(cnt_q) * IDX_W'(CHUNK));
    assign chunk_a = a_q[base +: CHUNK];
    assign chunk_b = b_q[base +: CHUNK];

    adder_chunk_cin #(
        .CHUNK    (CHUNK),
        .IMPL_TYPE(IMPL_TYPE)
    ) u_chunk (
        .a   (chunk_a),
        .b   (chunk_b),
        .cin (carry_q),
        .sum (chunk_sum),
        .cout(chunk_cout)
    );

    assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
    assign out_valid = (state_q == ST_DONE);
    assign accept    = in_valid && in_ready;

    assign Sum  = sum_q;
    assign Cout = cout_q;
    assign Ovf  = ovf_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                // DONE leaves only on the result handshake; accept (which
                // already includes out_ready in DONE) bypasses IDLE.
                if (accept) begin
                    a_d     = A;
                    b_d     = B ^ {WIDTH{sub}};
                    carry_d = sub;  // +1 completes the two's-complement of B
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end else if (state_q == ST_DONE && out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                sum_d[base +: CHUNK] = chunk_sum;
                carry_d              = chunk_cout;
                if (cnt_q == LAST_CNT) begin
                    cnt_d   = '0;
                    cout_d  = chunk_cout;
                    ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                              (chunk_sum[CHUNK-1] != a_q[WIDTH-1]);
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_add_int_serial.sv
module tb_add_int_serial;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, sub, out_valid, out_ready, Cout, Ovf;
    logic [63:0] A, B, Sum;

    // Sweep instances share one stimulus bus.
    logic [63:0] sw_a, sw_b;
    logic        sw_sub, sw_in_valid;
    logic [3:0]  sw_vld, sw_cout, sw_ovf, sw_rdy;
    logic [63:0] sw_sum0, sw_sum1, sw_sum2;
    logic [15:0] sw_sum3;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    add_int_serial #(.WIDTH(64), .CHUNK(8), .IMPL_TYPE(0)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
        .Sum(Sum), .Cout(Cout), .Ovf(Ovf));

    add_int_serial #(.WIDTH(64), .CHUNK(1), .IMPL_TYPE(0)) u_c1 (
        .clk(clk), .rst_n(rst_n), .in_valid(sw_in_valid), .in_ready(sw_rdy[0]),
        .A(sw_a), .B(sw_b), .sub(sw_sub), .out_valid(sw_vld[0]), .out_ready(1'b1),
        .Sum(sw_sum0), .Cout(sw_cout[0]), .Ovf(sw_ovf[0]));

    add_int_serial #(.WIDTH(64), .CHUNK(4), .IMPL_TYPE(1)) u_c4 (
        .clk(clk), .rst_n(rst_n), .in_valid(sw_in_valid), .in_ready(sw_rdy[1]),
        .A(sw_a), .B(sw_b), .sub(sw_sub), .out_valid(sw_vld[1]), .out_ready(1'b1),
        .Sum(sw_sum1), .Cout(sw_cout[1]), .Ovf(sw_ovf[1]));

    add_int_serial #(.WIDTH(64), .CHUNK(64), .IMPL_TYPE(1)) u_c64 (
        .clk(clk), .rst_n(rst_n), .in_valid(sw_in_valid), .in_ready(sw_rdy[2]),
        .A(sw_a), .B(sw_b), .sub(sw_sub), .out_valid(sw_vld[2]), .out_ready(1'b1),
        .Sum(sw_sum2), .Cout(sw_cout[2]), .Ovf(sw_ovf[2]));

    add_int_serial #(.WIDTH(16), .CHUNK(16), .IMPL_TYPE(0)) u_w16 (
        .clk(clk), .rst_n(rst_n), .in_valid(sw_in_valid), .in_ready(sw_rdy[3]),
        .A(sw_a[15:0]), .B(sw_b[15:0]), .sub(sw_sub), .out_valid(sw_vld[3]), .out_ready(1'b1),
        .Sum(sw_sum3), .Cout(sw_cout[3]), .Ovf(sw_ovf[3]));

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        s;
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    task automatic chk(input string nm, input logic [65:0] act, input logic [65:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Reference: whole-word arithmetic, returns {ovf, cout, sum}.
    function automatic logic [65:0] model(input int w, input logic [63:0] a,
                                          input logic [63:0] b, input logic s);
        logic [63:0] mask, am, bp, sm;
        logic [64:0] t;
        logic        co, ov;
        mask = (w >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
        am   = a & mask;
        bp   = (s ? ~b : b) & mask;
        t    = {1'b0, am} + {1'b0, bp} + {64'd0, s};
        sm   = t[63:0] & mask;
        co   = t[w];
        ov   = (am[w-1] == bp[w-1]) && (sm[w-1] != am[w-1]);
        return {ov, co, sm};
    endfunction

    function automatic logic [65:0] sw_get(input int k);
        case (k)
            0:       return {sw_ovf[0], sw_cout[0], sw_sum0};
            1:       return {sw_ovf[1], sw_cout[1], sw_sum1};
            2:       return {sw_ovf[2], sw_cout[2], sw_sum2};
            default: return {sw_ovf[3], sw_cout[3], 48'd0, sw_sum3};
        endcase
    endfunction

    // One operation on the main DUT from IDLE. Latency counts the accepting
    // edge as 1. A non-zero stall holds out_ready low for that many cycles.
    task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic s,
                          input int stall, output logic [65:0] res, output int lat);
        bit busy_ok, stable;
        A = a; B = b; sub = s; in_valid = 1'b1; out_ready = (stall == 0);
        @(posedge clk); #1;
        in_valid = 1'b0; A = ~a; B = {$urandom, $urandom}; sub = ~s;
        lat = 1; busy_ok = 1'b1;
        while (!out_valid && lat < 200) begin
            if (in_ready) busy_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        res = {Ovf, Cout, Sum};
        chk("in_ready_low_in_run", {65'd0, busy_ok}, 66'd1);
        if (stall > 0) begin
            stable = 1'b1;
            in_valid = 1'b1;
            for (int k = 0; k < stall; k++) begin
                @(posedge clk); #1;
                if (!out_valid || in_ready || {Ovf, Cout, Sum} !== res) stable = 1'b0;
            end
            in_valid = 1'b0;
            chk("stall_stable", {65'd0, stable}, 66'd1);
            out_ready = 1'b1;
        end
        @(posedge clk); #1;
    endtask

    task automatic sweep(input logic [63:0] a, input logic [63:0] b, input logic s);
        int          lat[4];
        logic [65:0] got[4];
        bit          done[4];
        int          nch[4];
        int          wid[4];
        int          cyc;
        nch = '{64, 16, 1, 1};
        wid = '{64, 64, 64, 16};
        for (int k = 0; k < 4; k++) begin lat[k] = 0; got[k] = '0; done[k] = 1'b0; end
        chk("sweep_ready", {62'd0, sw_rdy}, 66'hF);
        sw_a = a; sw_b = b; sw_sub = s; sw_in_valid = 1'b1;
        @(posedge clk); #1;
        sw_in_valid = 1'b0; sw_a = ~a; sw_b = ~b; sw_sub = ~s;
        cyc = 1;
        while (cyc < 200) begin
            for (int k = 0; k < 4; k++)
                if (!done[k] && sw_vld[k]) begin
                    done[k] = 1'b1; lat[k] = cyc; got[k] = sw_get(k);
                end
            if (done[0] && done[1] && done[2] && done[3]) break;
            @(posedge clk); #1;
            cyc++;
        end
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("sweep_lat_%0d", k), 66'(lat[k]), 66'(nch[k] + 1));
            chk($sformatf("sweep_res_%0d", k), got[k], model(wid[k], a, b, s));
        end
        @(posedge clk); #1;
    endtask

    initial begin
        vec_t        tbl[10];
        logic [65:0] res, exp_cur, exp_nxt;
        int          lat;
        bit          seen;
        logic [63:0] ra, rb;
        logic        rs;

        tbl[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0, 1'b1, 1'b0};
        tbl[1] = '{64'h5, 64'h7, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
        tbl[2] = '{64'h8000_0000_0000_0000, 64'h1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};
        tbl[3] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b1};
        tbl[4] = '{64'h3, 64'h4, 1'b0, 64'h7, 1'b0, 1'b0};
        tbl[5] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'h0, 1'b1, 1'b1};
        tbl[6] = '{64'h0, 64'h0, 1'b1, 64'h0, 1'b1, 1'b0};
        tbl[7] = '{64'hFF, 64'h1, 1'b0, 64'h100, 1'b0, 1'b0};
        tbl[8] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
        tbl[9] = '{64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b0, 64'h1234_5678_9ABC_DF00, 1'b0, 1'b0};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; A = '0; B = '0; sub = 1'b0;
        sw_a = '0; sw_b = '0; sw_sub = 1'b0; sw_in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        chk("reset_in_ready", {65'd0, in_ready}, 66'd1);
        chk("reset_out_valid", {65'd0, out_valid}, 66'd0);
        chk("reset_outputs", {Ovf, Cout, Sum}, 66'd0);

        // Directed table
        for (int i = 0; i < 10; i++) begin
            run_op(tbl[i].a, tbl[i].b, tbl[i].s, 0, res, lat);
            chk($sformatf("tbl%0d_lat", i), 66'(lat), 66'd9);
            chk($sformatf("tbl%0d_sum", i), {2'b00, res[63:0]}, {2'b00, tbl[i].sum});
            chk($sformatf("tbl%0d_cout", i), {65'd0, res[64]}, {65'd0, tbl[i].cout});
            chk($sformatf("tbl%0d_ovf", i), {65'd0, res[65]}, {65'd0, tbl[i].ovf});
        end

        // Backpressure
        for (int i = 0; i < 5; i++) begin
            ra = {$urandom, $urandom}; rb = {$urandom, $urandom}; rs = 1'($urandom);
            run_op(ra, rb, rs, 1 + int'($urandom_range(0, 5)), res, lat);
            chk("stall_res", res, model(64, ra, rb, rs));
            chk("stall_idle_after", {64'd0, out_valid, in_ready}, 66'b01);
        end

        // Streaming with the DONE->RUN bypass
        out_ready = 1'b1;
        ra = {$urandom, $urandom}; rb = {$urandom, $urandom}; rs = 1'($urandom);
        exp_cur = model(64, ra, rb, rs);
        A = ra; B = rb; sub = rs; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        for (int i = 0; i < 100; i++) begin
            while (!out_valid && lat < 50) begin
                @(posedge clk); #1;
                lat++;
            end
            chk("stream_lat", 66'(lat), 66'd9);
            chk("stream_res", {Ovf, Cout, Sum}, exp_cur);
            if (i < 99) begin
                ra = {$urandom, $urandom}; rb = {$urandom, $urandom}; rs = 1'($urandom);
                exp_nxt = model(64, ra, rb, rs);
                A = ra; B = rb; sub = rs; in_valid = 1'b1;
                @(posedge clk); #1;
                in_valid = 1'b0;
                exp_cur = exp_nxt;
                lat = 1;
            end else begin
                @(posedge clk); #1;
            end
        end

        // Reset in the middle of RUN
        A = 64'hFFFF_FFFF_FFFF_FFFF; B = 64'h0123_4567_89AB_CDEF; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", {65'd0, in_ready}, 66'd1);
        chk("midrst_out_valid", {65'd0, out_valid}, 66'd0);
        chk("midrst_outputs", {Ovf, Cout, Sum}, 66'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        seen = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        chk("midrst_no_valid", {65'd0, seen}, 66'd0);
        run_op(64'd3, 64'd4, 1'b0, 0, res, lat);
        chk("after_rst_lat", 66'(lat), 66'd9);
        chk("after_rst_res", res, {2'b00, 64'd7});

        // Parameter sweep
        sweep(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
        sweep(64'h8000_0000_0000_8000, 64'h1, 1'b1);
        for (int i = 0; i < 4; i++)
            sweep({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
